// File: rtl/fwd_pkg.sv
// Shared forwarding select encodings and stall FSM state type for operand_fwd_unit.
package fwd_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REG  = 2'b00;
  localparam fwd_sel_t FWD_WB   = 2'b01;
  localparam fwd_sel_t FWD_MEM  = 2'b10;
  localparam fwd_sel_t FWD_ZERO = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/fwd_select.sv
// Single-operand forwarding compare and 4:1 mux (zero > MEM > WB > register file).
module fwd_select
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   rdata,
  input  logic              mem_wen,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_wen,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   op,
  output fwd_sel_t          sel
);

  // Priority select: x0 is hard zero, the younger MEM result beats WB.
  always_comb begin
    op  = rdata;
    sel = FWD_REG;
    if (rs == '0) begin
      op  = '0;
      sel = FWD_ZERO;
    end else if (mem_wen && (mem_rd == rs)) begin
      op  = mem_data;
      sel = FWD_MEM;
    end else if (wb_wen && (wb_rd == rs)) begin
      op  = wb_data;
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/operand_fwd_unit.sv
// ID/EX operand forwarding with load-use stall FSM.
// Optional statistics counters are built when FWD_STATS_EN is defined.
module operand_fwd_unit
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_OPS  = 2,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [NUM_OPS*REG_AW-1:0] id_rs,
  input  logic [NUM_OPS*XLEN-1:0]   id_rdata,
  input  logic                      ex_wen,
  input  logic                      ex_is_load,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      mem_wen,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic [XLEN-1:0]           mem_data,
  input  logic                      wb_wen,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  output logic                      stall,
  output logic                      ex_valid,
  output logic [NUM_OPS*XLEN-1:0]   ex_op,
  output logic [NUM_OPS*2-1:0]      fwd_sel,
  output logic [31:0]               stat_fwd_cnt,
  output logic [31:0]               stat_stall_cnt
);

  localparam int unsigned CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  logic [NUM_OPS*XLEN-1:0] sel_op;
  logic [NUM_OPS*2-1:0]    sel_code;
  logic                    rs_hit;
  logic                    hazard;
  state_e                  state;
  logic [CW-1:0]           cnt;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    fwd_select #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
    ) u_sel (
      .rs       (id_rs[g*REG_AW +: REG_AW]),
      .rdata    (id_rdata[g*XLEN +: XLEN]),
      .mem_wen  (mem_wen),
      .mem_rd   (mem_rd),
      .mem_data (mem_data),
      .wb_wen   (wb_wen),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .op       (sel_op[g*XLEN +: XLEN]),
      .sel      (sel_code[g*2 +: 2])
    );
  end

  // Load-use hazard: a load in EX targets a nonzero register that ID reads.
  always_comb begin
    rs_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      if (id_rs[i*REG_AW +: REG_AW] == ex_rd) rs_hit = 1'b1;
    end
    hazard = id_valid && ex_is_load && ex_wen && (ex_rd != '0) && rs_hit;
  end

  // Stall is Mealy in the detect cycle; gated by rst_n so it drops with the async reset.
  assign stall = rst_n && (((state == IDLE) && hazard) || (state == STALL));

  // Stall FSM and EX operand registers; flush overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ex_valid <= 1'b0;
      ex_op    <= '0;
      fwd_sel  <= '0;
    end else if (flush) begin
      state    <= IDLE;
      cnt      <= '0;
      ex_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hazard) begin
            ex_valid <= 1'b0;
            if (LOAD_LAT > 1) begin
              state <= STALL;
              cnt   <= CW'(LOAD_LAT - 1);
            end
          end else begin
            ex_valid <= id_valid;
            ex_op    <= sel_op;
            fwd_sel  <= sel_code;
          end
        end
        STALL: begin
          ex_valid <= 1'b0;
          if (cnt == CW'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FWD_STATS_EN
  logic        capture;
  logic        any_fwd;
  logic [31:0] fwd_q;
  logic [31:0] stall_q;

  // A capture cycle forwards if any operand came from WB or MEM.
  always_comb begin
    capture = (state == IDLE) && !flush && !hazard;
    any_fwd = 1'b0;
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      if ((sel_code[i*2 +: 2] == FWD_WB) || (sel_code[i*2 +: 2] == FWD_MEM)) any_fwd = 1'b1;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q   <= '0;
      stall_q <= '0;
    end else begin
      if (capture && any_fwd && (fwd_q != '1)) fwd_q <= fwd_q + 32'd1;
      if (stall && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_fwd_cnt   = fwd_q;
  assign stat_stall_cnt = stall_q;
`else
  assign stat_fwd_cnt   = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: doc/operand_fwd_unit.md
Name: operand_fwd_unit

Overview:
- Parametrised successor to the 3-input forwarding mux. Sits at the ID/EX boundary of the RV32 pipeline.
- Per operand, it picks the register-file data, the WB value, the MEM value or zero, and registers the result into EX.
- It also detects load-use hazards and runs a stall FSM that inserts EX bubbles for a configurable load latency.

Parameters:
- XLEN, 32: datapath width.
- NUM_OPS, 2: number of source operands forwarded (rs1, rs2, optionally rs3).
- REG_AW, 5: register index width.
- LOAD_LAT, 1: stall cycles per load-use hazard (≥1).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill the instruction entering EX; abort any stall.
- id_valid  in  1  ID holds a valid instruction.
- id_rs  in  NUM_OPS*REG_AW  source register indices; operand i is at [i*REG_AW +: REG_AW].
- id_rdata  in  NUM_OPS*XLEN  register-file read data.
- ex_wen, ex_is_load  in  1 each  instruction currently in EX writes rd / is a load.
- ex_rd  in  REG_AW  EX destination register.
- mem_wen  in  1  MEM stage writes rd.
- mem_rd  in  REG_AW  MEM destination register.
- mem_data  in  XLEN  MEM result.
- wb_wen  in  1  WB stage writes rd.
- wb_rd  in  REG_AW  WB destination register.
- wb_data  in  XLEN  WB result.
- stall  out  1  freeze PC and IF/ID.
- ex_valid  out  1  EX operands valid.
- ex_op  out  NUM_OPS*XLEN  registered operands.
- fwd_sel  out  NUM_OPS*2  registered select used per operand.
- stat_fwd_cnt, stat_stall_cnt  out  32 each  see Optional Feature.

Behaviour:
- Reset: ex_valid=0, ex_op=0, fwd_sel=0, stall=0, FSM=IDLE, counter=0.
- Select priority per operand (combinational):
  - rs==0 → zero, sel 11.
  - else mem_wen && mem_rd==rs → mem_data, sel 10.
  - else wb_wen && wb_rd==rs → wb_data, sel 01.
  - else id_rdata, sel 00.
  - MEM beats WB when both match.
- hazard = id_valid && ex_is_load && ex_wen && ex_rd!=0 && ex_rd equals any id_rs.
- stall = (IDLE && hazard) || STALL. stall is Mealy in the detect cycle.
- FSM IDLE:
  - flush → ex_valid←0.
  - hazard → ex_valid←0 (bubble). If LOAD_LAT>1, go to STALL with cnt←LOAD_LAT-1; else stay IDLE.
  - otherwise ex_valid←id_valid; ex_op/fwd_sel←selected values. Latency is 1 cycle.
- FSM STALL:
  - ex_valid←0 each cycle; cnt decrements.
  - When cnt==1, go to IDLE. The hazard is re-evaluated in IDLE.
  - Total stall cycles = LOAD_LAT.
- flush: highest priority in every state. ex_valid←0 next edge, FSM←IDLE, cnt←0, stall deasserts next cycle. ex_op/fwd_sel hold their values.
- While ex_valid=0, ex_op and fwd_sel hold their last values; they are don't-care downstream.
- Reset mid-stall: immediate return to the reset values (asynchronous).

Optional Feature:
- Macro FWD_STATS_EN.
- Defined: stat_fwd_cnt increments by 1 on each IDLE capture cycle where any operand sel is 01 or 10. stat_stall_cnt increments on every cycle with stall=1. Both are 32-bit, saturate at all-ones, and reset to 0.
- Undefined: both ports are tied to 0 and no counter logic exists.

Decomposition:
- Package fwd_pkg holds:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, FWD_ZERO=2'b11.
  - State typedef {IDLE, STALL}.
- Sub-module fwd_select: combinational compare and 4:1 mux for one operand, instantiated NUM_OPS times via generate.

Test Plan:
- id_rs={2,1}; mem_rd=1 (mem_wen=1, mem_data=0xAAAA_0001); wb_rd=2 (wb_wen=1, wb_data=0xBBBB_0002) → next cycle ex_op={0xBBBB_0002,0xAAAA_0001}, fwd_sel={01,10}, ex_valid=1.
- mem_rd=wb_rd=5, both wen, rs1=5 → ex_op[0]=mem_data, sel 10. rs1=0 with mem_rd=0 and mem_wen=1 → ex_op[0]=0, sel 11.
- LOAD_LAT=1: ex_is_load=1, ex_rd=3, rs2=3 → stall=1 for exactly 1 cycle, ex_valid=0. The next cycle (mem_rd=3) forwards mem_data, sel 10.
- LOAD_LAT=3: load-use → stall high for 3 consecutive cycles, then capture. flush asserted in the 2nd stall cycle → stall=0 in the following cycle, ex_valid=0.
- rst_n pulsed low mid-STALL → stall, ex_valid, ex_op and fwd_sel are 0 asynchronously; the FSM restarts in IDLE.
- FWD_STATS_EN defined: 4 forwarded captures plus one 3-cycle stall → stat_fwd_cnt=4, stat_stall_cnt=3. Counters preloaded near all-ones saturate at 0xFFFF_FFFF.
